// File: rtl/master_alu_core.sv
// Single-cycle conditional ALU: evaluates the condition code against the incoming flags,
// computes the selected operation and registers Result, New_Flag and Executed.
module master_alu_core #(
    parameter int DATA_W = 32
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic signed [DATA_W-1:0] Reg1,
    input  logic signed [DATA_W-1:0] Reg2,
    input  logic        [4:0]        IV,
    input  logic        [3:0]        OpCode,
    input  logic        [3:0]        Cond,
    input  logic                     S,
    input  logic        [3:0]        Flag,
    output logic signed [DATA_W-1:0] Result,
    output logic        [3:0]        New_Flag,
    output logic                     Executed
);

    typedef enum logic [3:0] {
        OP_ADD = 4'd0, OP_SUB = 4'd1, OP_MUL = 4'd2,  OP_ORR = 4'd3,
        OP_AND = 4'd4, OP_EOR = 4'd5, OP_MOV = 4'd6,  OP_LSR = 4'd7,
        OP_LSL = 4'd8, OP_ROR = 4'd9, OP_LDR = 4'd10, OP_STR = 4'd11,
        OP_CMP = 4'd12
    } op_e;

    logic [DATA_W-1:0] result_q, result_d;
    logic [3:0]        flags_q, flags_d;
    logic              executed_q, executed_d;

    logic              flg_n, flg_z, flg_c, flg_v;
    logic              cond_pass;
    logic [DATA_W:0]   add_full;
    logic [DATA_W-1:0] sub_diff;
    logic              add_v, sub_v, sub_c;
    logic [DATA_W:0]   lsl_full;
    logic [DATA_W:0]   lsr_full;
    logic [2*DATA_W-1:0] ror_full;
    logic [DATA_W-1:0] op_val;
    logic [1:0]        op_cv;
    logic              wr_res, wr_flg;

    assign {flg_n, flg_z, flg_c, flg_v} = Flag;

    always_comb begin
        cond_pass = 1'b0;
        case (Cond)
            4'd0:  cond_pass = flg_z;
            4'd1:  cond_pass = !flg_z;
            4'd2:  cond_pass = flg_c;
            4'd3:  cond_pass = !flg_c;
            4'd4:  cond_pass = flg_n;
            4'd5:  cond_pass = !flg_n;
            4'd6:  cond_pass = flg_v;
            4'd7:  cond_pass = !flg_v;
            4'd8:  cond_pass = flg_c && !flg_z;
            4'd9:  cond_pass = !flg_c || flg_z;
            4'd10: cond_pass = (flg_n == flg_v);
            4'd11: cond_pass = (flg_n != flg_v);
            4'd12: cond_pass = !flg_z && (flg_n == flg_v);
            4'd13: cond_pass = flg_z || (flg_n != flg_v);
            4'd14: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    // Shifts use a widened operand so the last bit shifted out lands in a fixed position.
    assign add_full = {1'b0, Reg1} + {1'b0, Reg2};
    assign sub_diff = Reg1 - Reg2;
    assign sub_c    = ($unsigned(Reg1) >= $unsigned(Reg2));
    assign add_v    = (Reg1[DATA_W-1] == Reg2[DATA_W-1]) && (add_full[DATA_W-1] != Reg1[DATA_W-1]);
    assign sub_v    = (Reg1[DATA_W-1] != Reg2[DATA_W-1]) && (sub_diff[DATA_W-1] != Reg1[DATA_W-1]);
    assign lsl_full = {1'b0, Reg1} << IV;
    assign lsr_full = {Reg1, 1'b0} >> IV;
    assign ror_full = {Reg1, Reg1} >> IV;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        op_val     = '0;
        op_cv      = {flg_c, flg_v};
        wr_res     = 1'b0;
        wr_flg     = 1'b0;
        result_d   = result_q;
        flags_d    = Flag;
        executed_d = 1'b0;

        case (OpCode)
            OP_ADD: begin op_val = add_full[DATA_W-1:0]; op_cv = {add_full[DATA_W], add_v}; wr_res = 1'b1; wr_flg = S; end
            OP_SUB: begin op_val = sub_diff; op_cv = {sub_c, sub_v}; wr_res = 1'b1; wr_flg = S; end
            OP_MUL: begin op_val = Reg1 * Reg2;  wr_res = 1'b1; wr_flg = S; end
            OP_ORR: begin op_val = Reg1 | Reg2;  wr_res = 1'b1; wr_flg = S; end
            OP_AND: begin op_val = Reg1 & Reg2;  wr_res = 1'b1; wr_flg = S; end
            OP_EOR: begin op_val = Reg1 ^ Reg2;  wr_res = 1'b1; wr_flg = S; end
            OP_MOV: begin op_val = Reg2;         wr_res = 1'b1; wr_flg = S; end
            OP_LSR: begin
                op_val = lsr_full[DATA_W:1];
                op_cv  = {(IV == 5'd0) ? flg_c : lsr_full[0], flg_v};
                wr_res = 1'b1; wr_flg = S;
            end
            OP_LSL: begin
                op_val = lsl_full[DATA_W-1:0];
                op_cv  = {(IV == 5'd0) ? flg_c : lsl_full[DATA_W], flg_v};
                wr_res = 1'b1; wr_flg = S;
            end
            OP_ROR: begin
                op_val = ror_full[DATA_W-1:0];
                op_cv  = {(IV == 5'd0) ? flg_c : ror_full[DATA_W-1], flg_v};
                wr_res = 1'b1; wr_flg = S;
            end
            OP_LDR, OP_STR: begin op_val = Reg1 + {{(DATA_W-5){1'b0}}, IV}; wr_res = 1'b1; end
            OP_CMP: begin op_val = sub_diff; op_cv = {sub_c, sub_v}; wr_flg = 1'b1; end
            default: ;
        endcase

        if (cond_pass && (OpCode <= OP_CMP)) begin
            executed_d = 1'b1;
            if (wr_res) result_d = op_val;
            if (wr_flg) flags_d  = {op_val[DATA_W-1], ~|op_val, op_cv};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            result_q   <= '0;
            flags_q    <= '0;
            executed_q <= 1'b0;
        end else begin
            result_q   <= result_d;
            flags_q    <= flags_d;
            executed_q <= executed_d;
        end
    end

    assign Result   = result_q;
    assign New_Flag = flags_q;
    assign Executed = executed_q;

endmodule

// File: tb/tb_master_alu_core.sv
// Directed-vector bench for master_alu_core; expected values are hand-computed constants.
module tb_master_alu_core;

    logic               Clk = 1'b0;
    logic               Reset;
    logic signed [31:0] Reg1, Reg2;
    logic        [4:0]  IV;
    logic        [3:0]  OpCode, Cond, Flag;
    logic               S;
    logic signed [31:0] Result;
    logic        [3:0]  New_Flag;
    logic               Executed;

    int n_checks = 0;
    int n_fail   = 0;

    master_alu_core #(.DATA_W(32)) dut (
        .Clk(Clk), .Reset(Reset), .Reg1(Reg1), .Reg2(Reg2), .IV(IV),
        .OpCode(OpCode), .Cond(Cond), .S(S), .Flag(Flag),
        .Result(Result), .New_Flag(New_Flag), .Executed(Executed)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [31:0] res, input logic [3:0] nf, input logic ex);
        check({tag, ".result"},   Result,                  res);
        check({tag, ".new_flag"}, {28'd0, New_Flag},       {28'd0, nf});
        check({tag, ".executed"}, {31'd0, Executed},       {31'd0, ex});
    endtask

    // Drives one instruction 1 time unit after a rising edge, then waits for the edge that samples it.
    task automatic apply(input logic [3:0] c, input logic [3:0] op, input logic s_in, input logic [3:0] f,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] iv_in);
        Cond = c; OpCode = op; S = s_in; Flag = f; Reg1 = a; Reg2 = b; IV = iv_in;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset = 1'b1;
        Cond = 4'd14; OpCode = 4'd0; S = 1'b1; Flag = 4'b1111;
        Reg1 = 32'h1234_5678; Reg2 = 32'h1111_1111; IV = 5'd3;
        #2;
        expect_out("reset_initial", 32'h0, 4'b0000, 1'b0);
        @(posedge Clk); #1;
        expect_out("reset_held_over_edge", 32'h0, 4'b0000, 1'b0);
        Reset = 1'b0;

        apply(4'd14, 4'd0, 1'b1, 4'b0000, 32'h7FFF_FFFF, 32'h1, 5'd0);
        expect_out("add_overflow", 32'h8000_0000, 4'b1001, 1'b1);

        apply(4'd14, 4'd1, 1'b1, 4'b0000, 32'd5, 32'd5, 5'd0);
        expect_out("sub_equal", 32'h0, 4'b0110, 1'b1);

        apply(4'd14, 4'd0, 1'b0, 4'b0101, 32'd10, 32'd20, 5'd0);
        expect_out("add_s0_passthru", 32'd30, 4'b0101, 1'b1);

        apply(4'd0, 4'd0, 1'b1, 4'b0000, 32'd3, 32'd4, 5'd0);
        expect_out("eq_fail_hold", 32'd30, 4'b0000, 1'b0);

        apply(4'd14, 4'd8, 1'b1, 4'b0000, 32'h8000_0001, 32'h0, 5'd1);
        expect_out("lsl_carry", 32'h0000_0002, 4'b0010, 1'b1);

        apply(4'd14, 4'd10, 1'b1, 4'b1010, 32'h100, 32'h0, 5'd5);
        expect_out("ldr_addr", 32'h105, 4'b1010, 1'b1);

        apply(4'd14, 4'd12, 1'b0, 4'b0000, 32'd3, 32'd5, 5'd0);
        expect_out("cmp_s0_updates", 32'h105, 4'b1000, 1'b1);

        apply(4'd14, 4'd2, 1'b1, 4'b0011, 32'hFFFF_FFFD, 32'd7, 5'd0);
        expect_out("mul_signed", 32'hFFFF_FFEB, 4'b1011, 1'b1);

        apply(4'd14, 4'd7, 1'b1, 4'b0001, 32'h8000_0003, 32'h0, 5'd1);
        expect_out("lsr_carry", 32'h4000_0001, 4'b0011, 1'b1);

        apply(4'd14, 4'd9, 1'b1, 4'b0000, 32'h0000_0001, 32'h0, 5'd1);
        expect_out("ror_wrap", 32'h8000_0000, 4'b1010, 1'b1);

        apply(4'd14, 4'd8, 1'b1, 4'b0011, 32'h1234_5678, 32'h0, 5'd0);
        expect_out("lsl_iv0_keep_c", 32'h1234_5678, 4'b0011, 1'b1);

        apply(4'd14, 4'd9, 1'b1, 4'b0000, 32'h8765_4321, 32'h0, 5'd0);
        expect_out("ror_iv0", 32'h8765_4321, 4'b1000, 1'b1);

        apply(4'd14, 4'd13, 1'b1, 4'b1100, 32'd1, 32'd2, 5'd0);
        expect_out("reserved_op", 32'h8765_4321, 4'b1100, 1'b0);

        apply(4'd15, 4'd6, 1'b1, 4'b0110, 32'd0, 32'h0000_DEAD, 5'd0);
        expect_out("cond_nv", 32'h8765_4321, 4'b0110, 1'b0);

        apply(4'd12, 4'd6, 1'b1, 4'b1001, 32'd0, 32'h55, 5'd0);
        expect_out("gt_pass_mov", 32'h55, 4'b0001, 1'b1);

        apply(4'd11, 4'd6, 1'b1, 4'b1001, 32'd0, 32'h66, 5'd0);
        expect_out("lt_fail", 32'h55, 4'b1001, 1'b0);

        apply(4'd14, 4'd4, 1'b1, 4'b0000, 32'h0000_F0F0, 32'h0000_0F0F, 5'd0);
        expect_out("and_zero", 32'h0, 4'b0100, 1'b1);

        apply(4'd14, 4'd3, 1'b1, 4'b0011, 32'h8000_0000, 32'h0000_0F0F, 5'd0);
        expect_out("orr_neg", 32'h8000_0F0F, 4'b1011, 1'b1);

        apply(4'd14, 4'd5, 1'b1, 4'b0000, 32'hFFFF_0000, 32'hFF00_FF00, 5'd0);
        expect_out("eor", 32'h00FF_FF00, 4'b0000, 1'b1);

        apply(4'd14, 4'd1, 1'b1, 4'b0000, 32'd0, 32'd1, 5'd0);
        expect_out("sub_borrow", 32'hFFFF_FFFF, 4'b1000, 1'b1);

        apply(4'd14, 4'd0, 1'b1, 4'b0000, 32'hFFFF_FFFF, 32'd1, 5'd0);
        expect_out("add_carry_wrap", 32'h0, 4'b0110, 1'b1);

        apply(4'd14, 4'd1, 1'b1, 4'b0000, 32'h8000_0000, 32'd1, 5'd0);
        expect_out("sub_overflow", 32'h7FFF_FFFF, 4'b0011, 1'b1);

        apply(4'd8, 4'd11, 1'b1, 4'b0010, 32'hFFFF_FFFF, 32'd0, 5'd1);
        expect_out("str_hi_wrap", 32'h0, 4'b0010, 1'b1);

        apply(4'd14, 4'd6, 1'b1, 4'b0000, 32'd0, 32'hCAFE_0001, 5'd0);
        expect_out("pre_reset_value", 32'hCAFE_0001, 4'b1000, 1'b1);
        #3 Reset = 1'b1;
        #1;
        expect_out("async_reset_midcycle", 32'h0, 4'b0000, 1'b0);
        #1 Reset = 1'b0;

        apply(4'd14, 4'd0, 1'b1, 4'b0000, 32'd2, 32'd3, 5'd0);
        expect_out("first_edge_after_reset", 32'd5, 4'b0000, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/master_alu_core.md
MASTER_ALU_CORE -- requirements
Module: master_alu_core

Interface
REQ-001 Parameter: DATA_W, 32, operand/result width; the block SHALL support only 32.
REQ-002 Clk  input  1  the single clock; all state SHALL update on the rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 Reg1  input  32  signed operand A.
REQ-005 Reg2  input  32  signed operand B.
REQ-006 IV  input  5  immediate value / shift amount.
REQ-007 OpCode  input  4  operation select.
REQ-008 Cond  input  4  execution condition code.
REQ-009 S  input  1  flag-update enable.
REQ-010 Flag  input  4  current flags {N,Z,C,V}, bit3 = N through bit0 = V.
REQ-011 Result  output  32  signed registered result.
REQ-012 New_Flag  output  4  registered updated flags {N,Z,C,V}.
REQ-013 Executed  output  1  registered; 1 when the instruction sampled on the last edge passed its condition.

Function
REQ-014 Latency SHALL be exactly one clock: inputs sampled on a rising edge; Result, New_Flag and Executed valid after that edge.
REQ-015 Condition passes per Cond, evaluated on Flag:
- 0 EQ: Z
- 1 NE: !Z
- 2 CS: C
- 3 CC: !C
- 4 MI: N
- 5 PL: !N
- 6 VS: V
- 7 VC: !V
- 8 HI: C&!Z
- 9 LS: !C|Z
- 10 GE: N==V
- 11 LT: N!=V
- 12 GT: !Z&(N==V)
- 13 LE: Z|(N!=V)
- 14 AL: always
- 15 NV: never
REQ-016 OpCode map:
- 0 ADD: Reg1+Reg2
- 1 SUB: Reg1-Reg2
- 2 MUL: low 32 bits of signed Reg1*Reg2
- 3 ORR
- 4 AND
- 5 EOR
- 6 MOV: Reg2
- 7 LSR: Reg1>>IV, logical
- 8 LSL: Reg1<<IV
- 9 ROR: Reg1 rotated right by IV
- 10 LDR, 11 STR: address Reg1+IV, IV zero-extended
- 12 CMP: Reg1-Reg2, Result unchanged
- 13-15: reserved
REQ-017 When the condition fails, or OpCode is 13-15: Result SHALL hold its previous value, New_Flag SHALL equal Flag, and Executed SHALL be 0.
REQ-018 When the condition passes, Result SHALL take the operation value, except that CMP leaves Result unchanged; Executed SHALL be 1.
REQ-019 With S=0, New_Flag SHALL equal Flag, except that CMP always updates flags regardless of S.
REQ-020 ADD/SUB/CMP flag updates: N=result[31]; Z=(result==0); C=carry out (ADD) or no-borrow, i.e. Reg1>=Reg2 unsigned (SUB/CMP); V=signed overflow.
REQ-021 MUL and logical ops (ORR, AND, EOR, MOV) flag updates: N and Z are updated; C and V are copied from Flag.
REQ-022 Shift flag updates: N and Z are updated; C = last bit shifted out, or Flag.C when IV=0; V is copied from Flag.
REQ-023 LDR and STR SHALL never modify flags.
REQ-024 Wrap-around: all arithmetic is modulo 2^32; IV=0 SHALL yield an unshifted Reg1 for shifts and rotates.
REQ-025 Internal logic SHALL be a purely combinational next-state path plus output registers, with no other state.

Reset
REQ-026 While Reset=1, Result=0, New_Flag=4'b0000 and Executed=0, asynchronously and independent of Clk.
REQ-027 A Reset assertion between edges SHALL clear the outputs immediately.
REQ-028 The first edge after deassertion SHALL process that edge's inputs normally.

Verification
REQ-029 Cond=14, Op=0, S=1, Reg1=0x7FFFFFFF, Reg2=1 -> Result=0x80000000, New_Flag=1001 (N=1, V=1), one cycle later.
REQ-030 Cond=14, Op=1, S=1, Reg1=5, Reg2=5 -> Result=0, New_Flag=0110 (Z=1, C=1).
REQ-031 Cond=0 (EQ), Flag=0000, Op=0, Reg1=3, Reg2=4 -> Result holds its prior value, New_Flag=0000, Executed=0.
REQ-032 Cond=14, Op=8, S=1, Reg1=0x80000001, IV=1 -> Result=0x00000002, C=1, N=0, Z=0.
REQ-033 Cond=14, Op=10, Reg1=0x100, IV=5, Flag=1010 -> Result=0x105, New_Flag=1010.
REQ-034 Reset asserted mid-stream after a nonzero Result -> Result=0 and New_Flag=0000 before the next edge.
